// File: rtl/vram_write_drain.sv
// vram_write_drain: drains paired address/data entries from the write-buffer
// FIFOs and performs one timed SRAM write cycle per entry on the VRAM bus.
// The FIFO RAM outputs have one cycle of read latency, so each entry is
// primed for a cycle before it is latched and popped.
// Optional statistics (drain_count, desync_seen) are built when the macro
// VRAM_DRAIN_STATS_EN is defined; the default build omits them entirely.
module vram_write_drain #(
    parameter int AWIDTH    = 20,
    parameter int DWIDTH    = 16,
    parameter int SETUP_CYC = 1,
    parameter int WE_CYC    = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              addr_empty,
    input  logic [AWIDTH-1:0] addr_rdata,
    output logic              addr_rinc,
    input  logic              data_empty,
    input  logic [DWIDTH-1:0] data_rdata,
    output logic              data_rinc,
    output logic              vram_req,
    input  logic              vram_gnt,
    output logic [AWIDTH-1:0] vram_addr,
    output logic [DWIDTH-1:0] vram_dout,
    output logic              vram_oe,
    output logic              vram_ce_n,
    output logic              vram_we_n,
    output logic              busy
`ifdef VRAM_DRAIN_STATS_EN
    ,
    output logic [15:0]       drain_count,
    output logic              desync_seen
`endif
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PRIME  = 3'd1;
    localparam logic [2:0] S_LATCH  = 3'd2;
    localparam logic [2:0] S_REQ    = 3'd3;
    localparam logic [2:0] S_SETUP  = 3'd4;
    localparam logic [2:0] S_STROBE = 3'd5;
    localparam logic [2:0] S_HOLD   = 3'd6;

    // One down-counter serves all three bus phases; it is reloaded with
    // (phase length - 1) on entry and the phase ends when it reaches zero.
    localparam int MAX_CYC = (SETUP_CYC > WE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((WE_CYC > HOLD_CYC) ? WE_CYC : HOLD_CYC);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] WE_LD    = CNT_W'(WE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_dout;

    logic w_both;
    logic w_phase;
    logic w_cnt_done;

    // An entry is only started when both halves are present, so a lone
    // address or data word simply waits in IDLE without being popped.
    assign w_both     = !addr_empty && !data_empty;
    assign w_phase    = (r_state == S_SETUP) || (r_state == S_STROBE) || (r_state == S_HOLD);
    assign w_cnt_done = (r_cnt == '0);

    // Main sequencer: entry fetch, bus arbitration and SRAM write timing.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_dout  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_both) r_state <= S_PRIME;
                end
                S_PRIME: begin
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    r_addr  <= addr_rdata;
                    r_dout  <= data_rdata;
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    if (vram_gnt) begin
                        r_state <= S_SETUP;
                        r_cnt   <= SETUP_LD;
                    end
                end
                S_SETUP: begin
                    if (w_cnt_done) begin
                        r_state <= S_STROBE;
                        r_cnt   <= WE_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_STROBE: begin
                    if (w_cnt_done) begin
                        r_state <= S_HOLD;
                        r_cnt   <= HOLD_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_cnt_done) r_state <= w_both ? S_PRIME : S_IDLE;
                    else            r_cnt   <= r_cnt - 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Pops are decoded from LATCH so both FIFOs always advance together.
    assign addr_rinc = (r_state == S_LATCH);
    assign data_rinc = (r_state == S_LATCH);
    assign vram_req  = (r_state == S_REQ) || w_phase;
    assign vram_oe   = w_phase;
    assign vram_ce_n = !w_phase;
    assign vram_we_n = (r_state != S_STROBE);
    assign vram_addr = r_addr;
    assign vram_dout = r_dout;
    assign busy      = (r_state != S_IDLE);

`ifdef VRAM_DRAIN_STATS_EN
    logic [15:0] r_drain_cnt;
    logic [3:0]  r_desync_cnt;
    logic        r_desync;
    logic        w_one;

    assign w_one = addr_empty ^ data_empty;

    // Completed-write counter and sticky flag for long half-entry waits.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_drain_cnt  <= '0;
            r_desync_cnt <= '0;
            r_desync     <= 1'b0;
        end else begin
            if ((r_state == S_HOLD) && w_cnt_done && (r_drain_cnt != 16'hFFFF))
                r_drain_cnt <= r_drain_cnt + 16'd1;
            if ((r_state == S_IDLE) && w_one) begin
                if (r_desync_cnt == 4'd15) r_desync     <= 1'b1;
                else                       r_desync_cnt <= r_desync_cnt + 4'd1;
            end else begin
                r_desync_cnt <= '0;
            end
        end
    end

    assign drain_count = r_drain_cnt;
    assign desync_seen = r_desync;
`endif

endmodule

// File: tb/tb_vram_write_drain.sv
// Bench for vram_write_drain: FIFO pair model, random arbiter, and a write
// monitor that checks every SRAM strobe against the order entries were pushed.
module tb_vram_write_drain;

    localparam int WE_CYC = 2;

    logic        rclk;
    logic        rrst;
    logic        addr_empty;
    logic [19:0] addr_rdata;
    logic        addr_rinc;
    logic        data_empty;
    logic [15:0] data_rdata;
    logic        data_rinc;
    logic        vram_req;
    logic        vram_gnt;
    logic [19:0] vram_addr;
    logic [15:0] vram_dout;
    logic        vram_oe;
    logic        vram_ce_n;
    logic        vram_we_n;
    logic        busy;
`ifdef VRAM_DRAIN_STATS_EN
    logic [15:0] drain_count;
    logic        desync_seen;
`endif

    vram_write_drain dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .addr_empty (addr_empty),
        .addr_rdata (addr_rdata),
        .addr_rinc  (addr_rinc),
        .data_empty (data_empty),
        .data_rdata (data_rdata),
        .data_rinc  (data_rinc),
        .vram_req   (vram_req),
        .vram_gnt   (vram_gnt),
        .vram_addr  (vram_addr),
        .vram_dout  (vram_dout),
        .vram_oe    (vram_oe),
        .vram_ce_n  (vram_ce_n),
        .vram_we_n  (vram_we_n),
        .busy       (busy)
`ifdef VRAM_DRAIN_STATS_EN
        ,
        .drain_count(drain_count),
        .desync_seen(desync_seen)
`endif
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // FIFO pair model: pushed entries live in arrays, one-cycle RAM read.
    logic [19:0] amem [0:255];
    logic [15:0] dmem [0:255];
    int a_wptr = 0;
    int d_wptr = 0;
    int a_rptr = 0;
    int d_rptr = 0;

    assign addr_empty = (a_wptr == a_rptr);
    assign data_empty = (d_wptr == d_rptr);

    always @(posedge rclk) begin
        addr_rdata <= amem[a_rptr];
        data_rdata <= dmem[d_rptr];
        if (addr_rinc) a_rptr <= a_rptr + 1;
        if (data_rinc) d_rptr <= d_rptr + 1;
    end

    task automatic push_addr(input logic [19:0] a);
        amem[a_wptr] = a;
        a_wptr++;
    endtask

    task automatic push_data(input logic [15:0] d);
        dmem[d_wptr] = d;
        d_wptr++;
    endtask

    task automatic push_pair(input logic [19:0] a, input logic [15:0] d);
        push_addr(a);
        push_data(d);
    endtask

    int cyc = 0;
    always @(posedge rclk) cyc <= cyc + 1;

    // Write monitor: the k-th strobe must carry the k-th pushed entry.
    int   wr_cnt = 0;
    int   wr_cyc [0:511];
    int   we_run = 0;
    int   pop_a  = 0;
    int   pop_d  = 0;
    logic prev_we = 1'b1;
    logic abort_wr = 1'b0;

    always @(negedge rclk) begin
        if (!rrst) begin
            if (addr_rinc || data_rinc) begin
                chk("rinc_pair", 32'(data_rinc), 32'(addr_rinc));
                chk("pop_nonempty_a", 32'(addr_empty), 32'(0));
                chk("pop_nonempty_d", 32'(data_empty), 32'(0));
                if (addr_rinc) pop_a <= pop_a + 1;
                if (data_rinc) pop_d <= pop_d + 1;
            end
            if (!vram_we_n) begin
                chk("we_ce", 32'(vram_ce_n), 32'(0));
                chk("we_oe", 32'(vram_oe), 32'(1));
                chk("we_req", 32'(vram_req), 32'(1));
                if (prev_we === 1'b1) begin
                    chk("wr_addr", 32'(vram_addr), 32'(amem[wr_cnt]));
                    chk("wr_data", 32'(vram_dout), 32'(dmem[wr_cnt]));
                    wr_cyc[wr_cnt] <= cyc;
                    wr_cnt <= wr_cnt + 1;
                    we_run <= 1;
                end else begin
                    we_run <= we_run + 1;
                end
            end else if (prev_we === 1'b0 && !abort_wr) begin
                chk("we_width", 32'(we_run), 32'(WE_CYC));
            end
        end
        prev_we <= vram_we_n;
    end

    task automatic wait_idle(input int max_cyc, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge rclk); #1;
            if (!busy && a_rptr == a_wptr && d_rptr == d_wptr) begin
                ok = 1'b1;
                break;
            end
        end
        chk(tag, 32'(ok), 32'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int base;
        int pa;
        int pd;
        logic seen;

        rrst     = 1'b1;
        vram_gnt = 1'b0;

        // Reset held two cycles with an entry waiting in both FIFOs.
        push_pair(20'h0ABCD, 16'h5A5A);
        repeat (2) begin
            @(posedge rclk); #1;
            chk("rst_rinc", 32'(addr_rinc | data_rinc), 32'(0));
            chk("rst_req", 32'(vram_req), 32'(0));
            chk("rst_ce", 32'(vram_ce_n), 32'(1));
            chk("rst_we", 32'(vram_we_n), 32'(1));
            chk("rst_oe", 32'(vram_oe), 32'(0));
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_addr", 32'(vram_addr), 32'(0));
        end
        rrst = 1'b0;
        @(posedge rclk); #1;
        chk("post_rst_rinc", 32'(addr_rinc), 32'(0));
        chk("post_rst_req", 32'(vram_req), 32'(0));
        chk("post_rst_we", 32'(vram_we_n), 32'(1));
        vram_gnt = 1'b1;
        wait_idle(50, "to_first");
        chk("first_addr_kept", 32'(vram_addr), 32'h0ABCD);

        // Single write with grant already high; cycle 1 is PRIME.
        @(posedge rclk); #1;
        push_pair(20'h12345, 16'hBEEF);
        for (int c = 1; c <= 8; c++) begin
            @(posedge rclk); #1;
            chk("sw_rinc", 32'(addr_rinc), 32'(c == 2));
            chk("sw_we", 32'(vram_we_n), 32'(!(c == 5 || c == 6)));
            chk("sw_ce", 32'(vram_ce_n), 32'(!(c >= 4 && c <= 7)));
            chk("sw_req", 32'(vram_req), 32'(c >= 3 && c <= 7));
            if (c >= 3 && c <= 7) begin
                chk("sw_addr", 32'(vram_addr), 32'h12345);
                chk("sw_data", 32'(vram_dout), 32'hBEEF);
            end
        end
        wait_idle(20, "to_single");

        // Grant withheld for 10 cycles after the request.
        vram_gnt = 1'b0;
        push_pair(20'h0AAAA, 16'h1234);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge rclk); #1;
            if (vram_req) begin
                seen = 1'b1;
                break;
            end
        end
        chk("dg_req_seen", 32'(seen), 32'(1));
        for (int k = 0; k < 10; k++) begin
            chk("dg_wait_req", 32'(vram_req), 32'(1));
            chk("dg_wait_ce", 32'(vram_ce_n), 32'(1));
            chk("dg_wait_we", 32'(vram_we_n), 32'(1));
            @(posedge rclk); #1;
        end
        vram_gnt = 1'b1;
        @(posedge rclk); #1;
        chk("dg_setup_ce", 32'(vram_ce_n), 32'(0));
        chk("dg_setup_we", 32'(vram_we_n), 32'(1));
        wait_idle(20, "to_delayed");

        // Three entries back to back.
        base = wr_cnt;
        pa = pop_a;
        pd = pop_d;
        push_pair(20'h00010, 16'h1111);
        push_pair(20'h00020, 16'h2222);
        push_pair(20'h00030, 16'h3333);
        wait_idle(60, "to_b2b");
        chk("b2b_writes", 32'(wr_cnt - base), 32'(3));
        chk("b2b_period1", 32'(wr_cyc[base + 1] - wr_cyc[base]), 32'(7));
        chk("b2b_period2", 32'(wr_cyc[base + 2] - wr_cyc[base + 1]), 32'(7));
        chk("b2b_pops_a", 32'(pop_a - pa), 32'(3));
        chk("b2b_pops_d", 32'(pop_d - pd), 32'(3));

        // Address present without data: the block must wait, not pop.
        base = wr_cnt;
        push_addr(20'h00777);
        for (int k = 0; k < 20; k++) begin
            @(posedge rclk); #1;
            chk("ds_busy", 32'(busy), 32'(0));
            chk("ds_rinc", 32'(addr_rinc | data_rinc), 32'(0));
        end
`ifdef VRAM_DRAIN_STATS_EN
        chk("ds_flag", 32'(desync_seen), 32'(1));
`endif
        push_data(16'hD00D);
        wait_idle(30, "to_desync");
        chk("ds_write", 32'(wr_cnt - base), 32'(1));

        // Reset in the first strobe cycle aborts the write for good.
        base = wr_cnt;
        push_pair(20'h54321, 16'hCAFE);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge rclk); #1;
            if (!vram_we_n) begin
                seen = 1'b1;
                break;
            end
        end
        chk("mr_strobe_seen", 32'(seen), 32'(1));
        @(negedge rclk); #1;
        abort_wr = 1'b1;
        rrst = 1'b1;
        @(posedge rclk); #1;
        chk("mr_we", 32'(vram_we_n), 32'(1));
        chk("mr_ce", 32'(vram_ce_n), 32'(1));
        chk("mr_req", 32'(vram_req), 32'(0));
        chk("mr_busy", 32'(busy), 32'(0));
        rrst = 1'b0;
        repeat (15) @(posedge rclk);
        #1;
        chk("mr_no_rewrite", 32'(wr_cnt - base), 32'(1));
        chk("mr_idle", 32'(busy), 32'(0));
        abort_wr = 1'b0;

        // Random traffic: random grant latency, skewed address/data arrival.
        for (int i = 0; i < 1500; i++) begin
            @(negedge rclk); #1;
            if (!(vram_req && vram_gnt)) vram_gnt = ($urandom_range(0, 3) == 0);
            if (a_wptr < 240 && (a_wptr - d_wptr) < 3 && $urandom_range(0, 7) == 0)
                push_addr(20'($urandom));
            if (d_wptr < 240 && (d_wptr - a_wptr) < 3 && $urandom_range(0, 7) == 0)
                push_data(16'($urandom));
        end
        @(negedge rclk); #1;
        vram_gnt = 1'b1;
        while (a_wptr < d_wptr) push_addr(20'($urandom));
        while (d_wptr < a_wptr) push_data(16'($urandom));
        wait_idle(3000, "to_random");
        chk("total_writes", 32'(wr_cnt), 32'(a_wptr));
        chk("total_pops", 32'(pop_a), 32'(a_wptr));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_write_drain.md
Name: vram_write_drain

Overview:
Read-side consumer of the write buffer. It pops one entry each from the 20-bit address async FIFO and the 16-bit data async FIFO, both in the read-clock domain. It then arbitrates for the VRAM bus with a req/gnt handshake and performs one timed SRAM write cycle per entry. It sits between the write-buffer FIFO pair and the VRAM bus arbiter.

Parameters:
AWIDTH, 20, VRAM word address width; matches the address FIFO data width
DWIDTH, 16, VRAM data width; matches the data FIFO data width
SETUP_CYC, 1, cycles with address, data and ce_n valid before we_n falls (>=1)
WE_CYC, 2, cycles vram_we_n is held low (>=1)
HOLD_CYC, 1, cycles address, data and ce_n are held after we_n rises (>=1)

Ports:
rclk  in  1  system/read clock; single clock domain
rrst  in  1  reset; synchronous, active-high
addr_empty  in  1  address FIFO empty flag
addr_rdata  in  AWIDTH  address FIFO read data; block-RAM output, one-cycle read latency
addr_rinc  out  1  address FIFO pop strobe
data_empty  in  1  data FIFO empty flag
data_rdata  in  DWIDTH  data FIFO read data; one-cycle read latency
data_rinc  out  1  data FIFO pop strobe
vram_req  out  1  bus request to arbiter
vram_gnt  in  1  bus grant from arbiter
vram_addr  out  AWIDTH  SRAM address
vram_dout  out  DWIDTH  SRAM write data
vram_oe  out  1  data bus drive enable; 1 = drive vram_dout
vram_ce_n  out  1  SRAM chip enable, active-low
vram_we_n  out  1  SRAM write enable, active-low
busy  out  1  high whenever state != IDLE

Behaviour:
- Moore FSM: IDLE, PRIME, LATCH, REQ, SETUP, STROBE, HOLD. All outputs are registered or decoded from state only.
- Reset values: state IDLE; addr_rinc=0, data_rinc=0, vram_req=0, vram_oe=0, vram_ce_n=1, vram_we_n=1, vram_addr=0, vram_dout=0, busy=0.
- IDLE:
  - Move to PRIME only when addr_empty=0 and data_empty=0 are sampled together.
  - If only one FIFO is non-empty, stay in IDLE indefinitely. This is the desync wait: no pop, no error.
- PRIME: one cycle, so the FIFO RAM outputs reflect the head entry. Then go to LATCH.
- LATCH: one cycle.
  - Capture addr_rdata into vram_addr and data_rdata into vram_dout.
  - Pulse addr_rinc and data_rinc high for exactly this cycle, always together.
  - Then go to REQ.
- REQ: vram_req=1. Wait until vram_gnt is sampled 1, then go to SETUP. There is no timeout.
- SETUP: SETUP_CYC cycles; vram_ce_n=0, vram_oe=1, vram_we_n=1.
- STROBE: WE_CYC cycles; vram_ce_n=0, vram_oe=1, vram_we_n=0.
- HOLD: HOLD_CYC cycles; vram_ce_n=0, vram_oe=1, vram_we_n=1.
- Leaving HOLD:
  - Go to PRIME if both FIFOs are non-empty (back-to-back writes); otherwise go to IDLE.
  - vram_req is therefore low for at least PRIME+LATCH (2 cycles) between transactions.
- vram_req is 1 in states REQ, SETUP, STROBE and HOLD; 0 elsewhere.
- vram_addr and vram_dout are stable from REQ through HOLD and retain their last value afterwards.
- Grant contract: the arbiter does not revoke vram_gnt while vram_req=1. A gnt drop after REQ is ignored and the write completes.
- Phase counter: sized for max(SETUP_CYC, WE_CYC, HOLD_CYC); reloads on every phase entry.
- Timing with gnt already high, entries visible at edge 0 (defaults):
  - PRIME c1, LATCH c2 (pop), REQ c3, SETUP c4, STROBE c5-6, HOLD c7.
  - Next PRIME at c8, giving a sustained 7-cycle period per write (PRIME through HOLD).
- The FIFOs are never popped while empty, because emptiness is checked before every PRIME and this block is the only popper.
- Reset mid-operation: the next edge forces reset values (we_n high, ce_n high, req low). An entry already popped in LATCH is discarded, not replayed.

Optional Feature:
Macro VRAM_DRAIN_STATS_EN.
- Defined:
  - Adds output drain_count[15:0], which increments by 1 on each HOLD→exit transition, saturates at 0xFFFF, and clears on rrst.
  - Adds output desync_seen, a sticky flag set when IDLE observes exactly one FIFO non-empty for 16 consecutive cycles; cleared on rrst.
- Undefined: neither port exists and there is no counter logic. Core behaviour is identical.

Test Plan:
- Reset: hold rrst 2 cycles with both FIFOs non-empty -> during reset and the cycle after, rinc=0, req=0, ce_n=1, we_n=1, oe=0, busy=0.
- Single write: addr 0x12345, data 0xBEEF, gnt tied 1 -> both rinc pulse once at c2; we_n low exactly c5-c6; vram_addr=0x12345 and vram_dout=0xBEEF from c3 to c7; ce_n low c4-c7.
- Delayed grant: gnt rises 10 cycles after req -> req held high, ce_n=1 and we_n=1 throughout the wait; SETUP starts the cycle after gnt is sampled.
- Back-to-back: 3 entries (0x00010/0x1111, 0x00020/0x2222, 0x00030/0x3333) -> 3 we_n strobes, 7-cycle period, addr/data order preserved, exactly 3 rinc pulses per FIFO.
- Desync: address FIFO non-empty, data FIFO empty for 20 cycles -> FSM stays IDLE, no rinc. With VRAM_DRAIN_STATS_EN, desync_seen=1. When data arrives, the write proceeds normally.
- Reset mid-STROBE: assert rrst in the first STROBE cycle -> we_n=1, ce_n=1, req=0 on the next edge; busy=0; the popped entry is not rewritten.
